xoro_rng_stream: RTL
====================

// Module: xoro_rng_stream
// PURPOSE
//  Parametrised xoroshiro128+ random-number source with a buffered valid/ready stream output.
//  Successor to the fixed 4-bit RND_OUT generator in xoro_top.
//  Adds runtime reseed, a discarded warm-up run, selectable output width and a prefetch FIFO.
//  Feeds UART/LED logic or a CPU peripheral bus adapter.
// PARAMETERS
//  OUT_WIDTH  64                     bits per sample, 1..64, taken from result[63 -: OUT_WIDTH]
//  DEPTH      4                      prefetch FIFO entries, power of 2, >= 2
//  WARMUP     16                     generator steps discarded after reset/reseed, 0..65535
//  SEED0      64'h0123456789ABCDEF   default s0, used at reset and for zero-seed substitution
//  SEED1      64'hFEDCBA9876543210   default s1, same use as SEED0
// PORTS
//  clk        in   1                 single clock
//  reset      in   1                 synchronous, active-high reset
//  seed_load  in   1                 1-cycle request: load seed0/seed1, flush, re-warm
//  seed0      in   64                new s0
//  seed1      in   64                new s1
//  rnd_ready  in   1                 consumer accepts head sample
//  rnd_valid  out  1                 FIFO non-empty
//  rnd_data   out  OUT_WIDTH         FIFO head (show-ahead)
//  level      out  $clog2(DEPTH)+1   FIFO occupancy, 0..DEPTH
//  busy       out  1                 high while in WARMUP
// BEHAVIOUR
//  - Reset (sampled at posedge clk):
//    s0=SEED0, s1=SEED1; FIFO empty; rnd_valid=0, rnd_data=0, level=0.
//    FSM=WARMUP with cnt=WARMUP (busy=1), or RUN if WARMUP==0 (busy=0).
//  - Step: result=s0+s1 (mod 2^64); t=s1^s0.
//    s0'=rotl(s0,24)^t^(t<<16); s1'=rotl(t,37).
//  - WARMUP: one step per cycle, result discarded.
//    cnt decrements each step; on the step where cnt==1 the FSM enters RUN.
//  - RUN: step and push result[63 -: OUT_WIDTH] when (level<DEPTH) or (pop this cycle).
//    Otherwise hold state; no sample is ever dropped or skipped.
//  - pop = rnd_valid & rnd_ready.
//    Push and pop in the same cycle: level unchanged, order preserved.
//    rnd_ready is ignored when empty.
//  - Latency: a value pushed at edge N is visible on rnd_valid/rnd_data after edge N.
//    With WARMUP=0, rnd_valid rises 1 cycle after reset deasserts.
//  - rnd_data holds stable while rnd_valid=1 and rnd_ready=0.
//    Pointers wrap modulo DEPTH.
//  - seed_load (RUN or WARMUP):
//    Next edge: s0/s1 load; FIFO flushes (level=0, rnd_valid=0); cnt=WARMUP.
//    FSM=WARMUP, or RUN if WARMUP==0.
//    An all-zero {seed1,seed0} is replaced by {SEED1,SEED0}.
//  - seed_load wins over a same-cycle pop/push: the popped sample is lost, nothing is pushed.
//    reset wins over seed_load.
//  - Reset asserted mid-operation aborts everything at the next edge; no partial state survives.
// TESTING
//  1. OUT_WIDTH=64, WARMUP=0, seed_load s0=1,s1=2, rnd_ready=1
//     -> samples 64'h3, then 64'h0000_0060_0103_0003.
//  2. Hold rnd_ready=0 after reset, DEPTH=4
//     -> level 1,2,3,4 then stays 4; rnd_data stable; state frozen.
//     Release -> 4 consecutive pops match a golden C model with no gaps.
//  3. WARMUP=16 -> busy=1 for 16 cycles after reset.
//     First sample equals golden step #17 from SEED0/SEED1.
//  4. seed_load with seed0=seed1=0 -> output sequence identical to post-reset sequence.
//  5. seed_load asserted together with pop while FIFO full -> next cycle level=0, rnd_valid=0.
//     Sequence restarts from the new seed.
//  6. OUT_WIDTH=4, reset asserted for 1 cycle mid-stream
//     -> the next cycle matches post-reset values; rnd_data equals golden result[63:60].

Source files
------------

// File: rtl/xoro_rng_stream.sv
// xoroshiro128+ random source with warm-up, runtime reseed and a show-ahead prefetch FIFO.
// Samples are the top OUT_WIDTH bits of each generator result, delivered on a valid/ready stream.
module xoro_rng_stream #(
    parameter int          OUT_WIDTH = 64,
    parameter int          DEPTH     = 4,
    parameter int          WARMUP    = 16,
    parameter logic [63:0] SEED0     = 64'h0123456789ABCDEF,
    parameter logic [63:0] SEED1     = 64'hFEDCBA9876543210
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seed_load,
    input  logic [63:0]                seed0,
    input  logic [63:0]                seed1,
    input  logic                       rnd_ready,
    output logic                       rnd_valid,
    output logic [OUT_WIDTH-1:0]       rnd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {ST_WARM, ST_RUN} state_t;
    localparam state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARM;

    state_t                state, state_nx;
    logic [15:0]           cnt;
    logic [63:0]           s0, s1, t, result, s0_nx, s1_nx;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [OUT_WIDTH-1:0]  mem [DEPTH];
    logic                  pop, push, step, seed_zero;

    always_comb begin
        t      = s0 ^ s1;
        result = s0 + s1;
        s0_nx  = {s0[39:0], s0[63:40]} ^ t ^ (t << 16);
        s1_nx  = {t[26:0], t[63:27]};
    end

    assign pop       = rnd_valid & rnd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = (state == ST_RUN) && ((level < LW'(DEPTH)) || pop);
    assign step      = (state == ST_WARM) || push;
    assign seed_zero = ({seed1, seed0} == 128'd0);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (seed_load)
            state_nx = ST_INIT;
        else if (state == ST_WARM && cnt == 16'd1)
            state_nx = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0     <= SEED0;
            s1     <= SEED1;
            cnt    <= 16'(WARMUP);
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (seed_load) begin
            s0     <= seed_zero ? SEED0 : seed0;
            s1     <= seed_zero ? SEED1 : seed1;
            cnt    <= 16'(WARMUP);
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (step) begin
                s0 <= s0_nx;
                s1 <= s1_nx;
            end
            if (state == ST_WARM) cnt <= cnt - 16'd1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through rnd_valid.
    always_ff @(posedge clk) begin
        if (!reset && !seed_load && push)
            mem[wr_ptr] <= result[63 -: OUT_WIDTH];
    end

    assign rnd_valid = (level != '0);
    assign rnd_data  = rnd_valid ? mem[rd_ptr] : '0;
    assign busy      = (state == ST_WARM);
endmodule
